multicycle_ctrl_fsm: RTL and testbench
======================================

Name: multicycle_ctrl_fsm

Overview:
Main control state machine for the multicycle MIPS-subset datapath. It sequences fetch, decode, execute, memory and writeback over several cycles per instruction for R-type, lw, sw, addi, beq and j. It drives every datapath mux select and write enable, and handshakes with the shared instruction/data memory.

Parameters:
MEM_TIMEOUT, 16, max cycles to wait for mem_ready in a memory state before aborting (min 2)
CNT_W, 5, width of the wait counter; must hold MEM_TIMEOUT

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  6  IR[31:26], stable from DECODE until instruction end
zero  in  1  ALU zero flag (informational; PC gating is external via pc_write_cond)
mem_ready  in  1  memory completes current access this cycle
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if ALU zero
i_or_d  out  1  mem address select: 0=PC, 1=ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  load instruction register
mem_to_reg  out  1  writeback select: 1=MDR, 0=ALUOut
reg_dst  out  1  dest reg: 1=rd, 0=rt
reg_write  out  1  register file write
alu_src_a  out  1  0=PC, 1=regA
alu_src_b  out  2  00=regB, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
alu_op  out  2  00=add, 01=sub(beq), 10=funct, 11=addi
pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump target
instr_done  out  1  one-cycle pulse on last cycle of each retired instruction
illegal_op  out  1  one-cycle pulse in DECODE for an unknown opcode
mem_err  out  1  one-cycle pulse on memory timeout
state_dbg  out  4  current state encoding

Behaviour:
- Opcodes: RTYPE 000000, LW 001000, SW 010000, ADDI 000010, BEQ 000100, J 100000.
- State register is asynchronously reset to IDLE. All outputs are 0 in IDLE and while rst_n is low. IDLE goes to FETCH on the first clock after rst_n deasserts.
- Outputs are decoded from state. Any output not listed for a state is 0.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00. ir_write and pc_write are gated by mem_ready. Stay in FETCH until mem_ready=1, then go to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (precomputes the branch target). Dispatch: LW/SW go to MEM_ADDR, RTYPE to R_EXEC, ADDI to ADDI_EXEC, BEQ to BRANCH, J to JUMP. Any other opcode pulses illegal_op and goes to FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to MEM_RD if LW, else MEM_WR.
- MEM_RD: mem_read=1, i_or_d=1. Waits for mem_ready, then goes to MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1. Goes to FETCH.
- MEM_WR: mem_write=1, i_or_d=1. Waits for mem_ready. instr_done=1 on the ready cycle, then goes to FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Goes to R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1. Goes to FETCH.
- ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=11. Goes to ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1. Goes to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1. Goes to FETCH.
- JUMP: pc_write=1, pc_source=10, instr_done=1. Goes to FETCH.
- Instruction latency with zero memory wait: lw 5, sw 4, R/addi 4, beq/j 3 cycles.
- Wait counter:
  - Clears on every state change.
  - Increments each cycle in FETCH/MEM_RD/MEM_WR while mem_ready=0.
  - When the count reaches MEM_TIMEOUT-1 with mem_ready still 0: pulse mem_err, go to FETCH, no instr_done.
  - mem_ready arriving in the same cycle as the timeout wins; the access completes normally.
- Timeout in FETCH restarts FETCH and PC is not written. Timeout in MEM_RD/MEM_WR abandons the instruction with no register or memory write.
- Reset mid-instruction returns to IDLE immediately. No partial writes are issued after reset assertion.
- mem_read and mem_write are never both 1. ir_write is 1 only in FETCH.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state enum (IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_RD=4, MEM_WB=5, MEM_WR=6, R_EXEC=7, R_WB=8, ADDI_EXEC=9, ADDI_WB=10, BRANCH=11, JUMP=12)
  - opcode constants
  - ALUOp, ALUSrcB and PCSource encodings
- Sub-module mem_wait_timer: clear, count-enable, ready in; timeout pulse out; parameterised by MEM_TIMEOUT/CNT_W.

Test Plan:
- Reset then LW (opcode 001000), mem_ready tied 1 -> states 0,1,2,3,4,5,1. ir_write and pc_write high at cycle 1. reg_write=1 with mem_to_reg=1 at cycle 5. instr_done once.
- R-type with mem_ready=1 -> R_WB at fetch+3 with reg_dst=1, alu_op=10 in R_EXEC. Then BEQ -> pc_write_cond=1, pc_source=01 at fetch+2.
- SW with mem_ready held low 3 cycles in MEM_WR -> mem_write high for 4 cycles, mem_read=0 throughout, instr_done on the 4th cycle.
- Opcode 111111 -> illegal_op pulse in DECODE, next state FETCH, no reg_write/mem_write.
- MEM_TIMEOUT=4, mem_ready stuck 0 in MEM_RD -> mem_err at 4th wait cycle, back to FETCH, no reg_write. Repeat with mem_ready rising on that cycle -> normal MEM_WB, no mem_err.
- rst_n low during MEM_WR (async, mid-cycle) -> all outputs 0 immediately, state_dbg=0. After release -> FETCH on the next edge.

Source files
------------

// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared types and encodings for the multicycle MIPS-subset control FSM.
package mc_ctrl_pkg;

  localparam int unsigned STATE_W  = 4;
  localparam int unsigned OPCODE_W = 6;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_RD    = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WR    = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_ADDI_EXEC = 4'd9,
    S_ADDI_WB   = 4'd10,
    S_BRANCH    = 4'd11,
    S_JUMP      = 4'd12
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b001000;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b010000;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b000010;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b100000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_ADDI  = 2'b11;

  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // States that hold a memory access open and are subject to the timeout
  function automatic logic is_mem_wait(state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Control bundle between the FSM (master) and the datapath/memory (slave).
interface multicycle_ctrl_fsm_if;
  import mc_ctrl_pkg::*;

  logic [OPCODE_W-1:0] opcode;
  logic                zero;
  logic                mem_ready;

  logic                pc_write;
  logic                pc_write_cond;
  logic                i_or_d;
  logic                mem_read;
  logic                mem_write;
  logic                ir_write;
  logic                mem_to_reg;
  logic                reg_dst;
  logic                reg_write;
  logic                alu_src_a;
  logic [1:0]          alu_src_b;
  logic [1:0]          alu_op;
  logic [1:0]          pc_source;
  logic                instr_done;
  logic                illegal_op;
  logic                mem_err;
  logic [STATE_W-1:0]  state_dbg;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, instr_done, illegal_op, mem_err, state_dbg
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, instr_done, illegal_op, mem_err, state_dbg
  );

endinterface

// File: rtl/multicycle_ctrl_fsm_mem_wait_timer.sv
// Counts stalled cycles of a memory access and flags the abort cycle.
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic cnt_en_i,
  input  logic ready_i,
  output logic timeout_c
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Wait counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // Clear wins over counting; count only stalled cycles
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)                  cnt_d = '0;
    else if (cnt_en_i && !ready_i) cnt_d = cnt_q + CNT_W'(1);
  end

  // A late ready on the last allowed cycle still completes the access
  assign timeout_c = cnt_en_i && !ready_i && (cnt_q == LAST);

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle MIPS-subset main control FSM: sequences fetch/decode/execute/
// memory/writeback and drives all datapath selects and write enables.
module multicycle_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 5
) (
  input logic                  clk,
  input logic                  rst_n,
  multicycle_ctrl_fsm_if.master bus
);

  state_t state_q, state_d;

  logic       timeout_c;
  logic       wait_clear_c;
  logic       wait_en_c;

  logic       pc_write_c, pc_write_cond_c, i_or_d_c, mem_read_c, mem_write_c;
  logic       ir_write_c, mem_to_reg_c, reg_dst_c, reg_write_c, alu_src_a_c;
  logic [1:0] alu_src_b_c, alu_op_c, pc_source_c;
  logic       instr_done_c, illegal_op_c, mem_err_c;

  // The zero flag only gates the PC outside this block
  logic unused_zero;
  assign unused_zero = bus.zero;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Memory wait timer restarts on every state change and after each abort
  assign wait_en_c    = is_mem_wait(state_q);
  assign wait_clear_c = (state_d != state_q) || timeout_c;

  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) u_wait_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (wait_clear_c),
    .cnt_en_i  (wait_en_c),
    .ready_i   (bus.mem_ready),
    .timeout_c (timeout_c)
  );

  // Next-state and control decode
  always_comb begin
    state_d         = state_q;
    pc_write_c      = 1'b0;
    pc_write_cond_c = 1'b0;
    i_or_d_c        = 1'b0;
    mem_read_c      = 1'b0;
    mem_write_c     = 1'b0;
    ir_write_c      = 1'b0;
    mem_to_reg_c    = 1'b0;
    reg_dst_c       = 1'b0;
    reg_write_c     = 1'b0;
    alu_src_a_c     = 1'b0;
    alu_src_b_c     = SRCB_REGB;
    alu_op_c        = ALUOP_ADD;
    pc_source_c     = PCSRC_ALU;
    instr_done_c    = 1'b0;
    illegal_op_c    = 1'b0;
    mem_err_c       = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_FETCH;

      S_FETCH: begin
        mem_read_c  = 1'b1;
        alu_src_b_c = SRCB_FOUR;
        ir_write_c  = bus.mem_ready;
        pc_write_c  = bus.mem_ready;
        if (bus.mem_ready) begin
          state_d = S_DECODE;
        end else if (timeout_c) begin
          mem_err_c = 1'b1;
          state_d   = S_FETCH;
        end
      end

      S_DECODE: begin
        alu_src_b_c = SRCB_IMM_SH2;
        case (bus.opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_RTYPE:     state_d = S_R_EXEC;
          OP_ADDI:      state_d = S_ADDI_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default: begin
            illegal_op_c = 1'b1;
            state_d      = S_FETCH;
          end
        endcase
      end

      S_MEM_ADDR: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = SRCB_IMM;
        state_d     = (bus.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end

      S_MEM_RD: begin
        mem_read_c = 1'b1;
        i_or_d_c   = 1'b1;
        if (bus.mem_ready) begin
          state_d = S_MEM_WB;
        end else if (timeout_c) begin
          mem_err_c = 1'b1;
          state_d   = S_FETCH;
        end
      end

      S_MEM_WB: begin
        reg_write_c  = 1'b1;
        mem_to_reg_c = 1'b1;
        instr_done_c = 1'b1;
        state_d      = S_FETCH;
      end

      S_MEM_WR: begin
        mem_write_c = 1'b1;
        i_or_d_c    = 1'b1;
        if (bus.mem_ready) begin
          instr_done_c = 1'b1;
          state_d      = S_FETCH;
        end else if (timeout_c) begin
          mem_err_c = 1'b1;
          state_d   = S_FETCH;
        end
      end

      S_R_EXEC: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = SRCB_REGB;
        alu_op_c    = ALUOP_FUNCT;
        state_d     = S_R_WB;
      end

      S_R_WB: begin
        reg_write_c  = 1'b1;
        reg_dst_c    = 1'b1;
        instr_done_c = 1'b1;
        state_d      = S_FETCH;
      end

      S_ADDI_EXEC: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = SRCB_IMM;
        alu_op_c    = ALUOP_ADDI;
        state_d     = S_ADDI_WB;
      end

      S_ADDI_WB: begin
        reg_write_c  = 1'b1;
        instr_done_c = 1'b1;
        state_d      = S_FETCH;
      end

      S_BRANCH: begin
        alu_src_a_c     = 1'b1;
        alu_src_b_c     = SRCB_REGB;
        alu_op_c        = ALUOP_SUB;
        pc_write_cond_c = 1'b1;
        pc_source_c     = PCSRC_ALUOUT;
        instr_done_c    = 1'b1;
        state_d         = S_FETCH;
      end

      S_JUMP: begin
        pc_write_c   = 1'b1;
        pc_source_c  = PCSRC_JUMP;
        instr_done_c = 1'b1;
        state_d      = S_FETCH;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Drive the control bundle
  assign bus.pc_write      = pc_write_c;
  assign bus.pc_write_cond = pc_write_cond_c;
  assign bus.i_or_d        = i_or_d_c;
  assign bus.mem_read      = mem_read_c;
  assign bus.mem_write     = mem_write_c;
  assign bus.ir_write      = ir_write_c;
  assign bus.mem_to_reg    = mem_to_reg_c;
  assign bus.reg_dst       = reg_dst_c;
  assign bus.reg_write     = reg_write_c;
  assign bus.alu_src_a     = alu_src_a_c;
  assign bus.alu_src_b     = alu_src_b_c;
  assign bus.alu_op        = alu_op_c;
  assign bus.pc_source     = pc_source_c;
  assign bus.instr_done    = instr_done_c;
  assign bus.illegal_op    = illegal_op_c;
  assign bus.mem_err       = mem_err_c;
  assign bus.state_dbg     = state_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: instruction-level reference model with a
// scoreboard queue of expected per-cycle control vectors.
module tb_multicycle_ctrl_fsm;

  localparam int unsigned TO = 4;

  // State numbers as published on state_dbg
  localparam int ST_IDLE = 0, ST_FETCH = 1, ST_DECODE = 2, ST_MEM_ADDR = 3;
  localparam int ST_MEM_RD = 4, ST_MEM_WB = 5, ST_MEM_WR = 6, ST_R_EXEC = 7;
  localparam int ST_R_WB = 8, ST_ADDI_EXEC = 9, ST_ADDI_WB = 10;
  localparam int ST_BRANCH = 11, ST_JUMP = 12;

  localparam logic [5:0] O_R = 6'b000000, O_LW = 6'b001000, O_SW = 6'b010000;
  localparam logic [5:0] O_ADDI = 6'b000010, O_BEQ = 6'b000100, O_J = 6'b100000;

  typedef logic [22:0] ovec_t;

  logic clk;
  logic rst_n;

  multicycle_ctrl_fsm_if bus();

  multicycle_ctrl_fsm #(.MEM_TIMEOUT(TO), .CNT_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  ovec_t      expq[$];
  int         plan[$];     // remaining steps of the current instruction
  int         wcnt;        // stalled cycles in the current memory access
  logic [5:0] opq[$];
  bit         rq[$];
  logic [5:0] cur_op;

  function automatic bit is_legal(logic [5:0] op);
    return op == O_R || op == O_LW || op == O_SW || op == O_ADDI ||
           op == O_BEQ || op == O_J;
  endfunction

  // Control vector each state must present
  function automatic ovec_t exp_out(int st, bit rdy, logic [5:0] op, bit tmo);
    logic pcw = 0, pcwc = 0, iord = 0, mrd = 0, mwr = 0, irw = 0;
    logic m2r = 0, rdst = 0, rw = 0, sa = 0, done = 0, ill = 0, merr = 0;
    logic [1:0] sb = 0, aop = 0, psrc = 0;
    case (st)
      ST_FETCH:     begin mrd = 1; sb = 2'b01; irw = rdy; pcw = rdy; merr = tmo; end
      ST_DECODE:    begin sb = 2'b11; ill = !is_legal(op); end
      ST_MEM_ADDR:  begin sa = 1; sb = 2'b10; end
      ST_MEM_RD:    begin mrd = 1; iord = 1; merr = tmo; end
      ST_MEM_WB:    begin rw = 1; m2r = 1; done = 1; end
      ST_MEM_WR:    begin mwr = 1; iord = 1; done = rdy; merr = tmo; end
      ST_R_EXEC:    begin sa = 1; aop = 2'b10; end
      ST_R_WB:      begin rw = 1; rdst = 1; done = 1; end
      ST_ADDI_EXEC: begin sa = 1; sb = 2'b10; aop = 2'b11; end
      ST_ADDI_WB:   begin rw = 1; done = 1; end
      ST_BRANCH:    begin sa = 1; aop = 2'b01; pcwc = 1; psrc = 2'b01; done = 1; end
      ST_JUMP:      begin pcw = 1; psrc = 2'b10; done = 1; end
      default:      ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, sa, sb, aop, psrc,
            done, ill, merr, 4'(st)};
  endfunction

  function automatic ovec_t dut_vec();
    return {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read,
            bus.mem_write, bus.ir_write, bus.mem_to_reg, bus.reg_dst,
            bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
            bus.pc_source, bus.instr_done, bus.illegal_op, bus.mem_err,
            bus.state_dbg};
  endfunction

  // Steps that follow a completed fetch, by instruction class
  function automatic void push_plan(logic [5:0] op);
    plan.push_back(ST_DECODE);
    case (op)
      O_LW:   begin plan.push_back(ST_MEM_ADDR); plan.push_back(ST_MEM_RD); plan.push_back(ST_MEM_WB); end
      O_SW:   begin plan.push_back(ST_MEM_ADDR); plan.push_back(ST_MEM_WR); end
      O_R:    begin plan.push_back(ST_R_EXEC); plan.push_back(ST_R_WB); end
      O_ADDI: begin plan.push_back(ST_ADDI_EXEC); plan.push_back(ST_ADDI_WB); end
      O_BEQ:  plan.push_back(ST_BRANCH);
      O_J:    plan.push_back(ST_JUMP);
      default: ;
    endcase
  endfunction

  function automatic bit is_wait(int st);
    return st == ST_FETCH || st == ST_MEM_RD || st == ST_MEM_WR;
  endfunction

  function automatic void advance(bit rdy, logic [5:0] op);
    int st = plan[0];
    if (is_wait(st)) begin
      if (rdy) begin
        void'(plan.pop_front());
        wcnt = 0;
        if (st == ST_FETCH) push_plan(op);
      end else if (wcnt == int'(TO) - 1) begin
        plan.delete();
        wcnt = 0;
      end else begin
        wcnt++;
      end
    end else begin
      void'(plan.pop_front());
      wcnt = 0;
    end
    if (plan.size() == 0) plan.push_back(ST_FETCH);
  endfunction

  function automatic logic [5:0] rand_op();
    logic [5:0] legal [6] = '{O_R, O_LW, O_SW, O_ADDI, O_BEQ, O_J};
    logic [5:0] op;
    if ($urandom_range(0, 7) != 0) return legal[$urandom_range(0, 5)];
    op = 6'b111111;
    for (int k = 0; k < 8; k++) begin
      op = 6'($urandom);
      if (!is_legal(op)) break;
    end
    return is_legal(op) ? 6'b111111 : op;
  endfunction

  task automatic check(string name, ovec_t act, ovec_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // One clock of stimulus; expected response goes to the scoreboard
  task automatic step(input bit release_rst);
    bit rdy;
    bit tmo;
    int st;
    @(negedge clk);
    if (release_rst) rst_n = 1'b1;
    st  = plan[0];
    rdy = (rq.size() > 0) ? rq.pop_front() : ($urandom_range(0, 3) != 0);
    if (st == ST_FETCH) begin
      if (rdy && opq.size() > 0) cur_op = opq.pop_front();
      else                       cur_op = rand_op();
    end
    bus.mem_ready = rdy;
    bus.opcode    = cur_op;
    bus.zero      = 1'($urandom_range(0, 1));
    tmo = is_wait(st) && !rdy && (wcnt == int'(TO) - 1);
    expq.push_back(exp_out(st, rdy, cur_op, tmo));
    if (rst_n) advance(rdy, cur_op);
  endtask

  task automatic push_rdy(input int n, input bit v);
    for (int k = 0; k < n; k++) rq.push_back(v);
  endtask

  // Asynchronous reset in the middle of a cycle
  task automatic async_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", dut_vec(), 23'h0);
    plan.delete();
    plan.push_back(ST_IDLE);
    wcnt = 0;
    step(1'b0);
    step(1'b1);
  endtask

  // Monitor: compare DUT against the scoreboard every cycle
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (expq.size() > 0) check("cycle", dut_vec(), expq.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    bus.opcode    = 6'd0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b0;
    cur_op        = 6'd0;
    wcnt          = 0;
    plan.push_back(ST_IDLE);
    step(1'b0);
    step(1'b0);
    step(1'b1);

    // LW with zero wait: states 0,1,2,3,4,5 then FETCH
    opq.push_back(O_LW);   push_rdy(5, 1'b1); repeat (5) step(1'b0);
    // R-type then BEQ
    opq.push_back(O_R);    push_rdy(4, 1'b1); repeat (4) step(1'b0);
    opq.push_back(O_BEQ);  push_rdy(3, 1'b1); repeat (3) step(1'b0);
    // SW with three stalled cycles in MEM_WR, ready on the last allowed one
    opq.push_back(O_SW);   push_rdy(3, 1'b1); push_rdy(3, 1'b0); push_rdy(1, 1'b1);
    repeat (7) step(1'b0);
    // Unknown opcode
    opq.push_back(6'b111111); push_rdy(2, 1'b1); repeat (2) step(1'b0);
    // LW timing out in MEM_RD
    opq.push_back(O_LW);   push_rdy(3, 1'b1); push_rdy(4, 1'b0); repeat (7) step(1'b0);
    // LW with ready arriving on the timeout cycle
    opq.push_back(O_LW);   push_rdy(3, 1'b1); push_rdy(3, 1'b0); push_rdy(2, 1'b1);
    repeat (8) step(1'b0);
    // Fetch timeout, then J and ADDI
    push_rdy(4, 1'b0); repeat (4) step(1'b0);
    opq.push_back(O_J);    push_rdy(3, 1'b1); repeat (3) step(1'b0);
    opq.push_back(O_ADDI); push_rdy(4, 1'b1); repeat (4) step(1'b0);
    // SW interrupted by reset while in MEM_WR
    opq.push_back(O_SW);   push_rdy(3, 1'b1); push_rdy(1, 1'b0); repeat (4) step(1'b0);
    async_reset();

    // Randomized traffic with occasional stuck-low bursts
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 40) == 0) push_rdy(int'(TO), 1'b0);
      step(1'b0);
      if (i == 400) async_reset();
    end

    repeat (3) @(negedge clk);
    #2;
    if (expq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", expq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
